pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/mdu_stall_timer.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 84 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU timer state
// encoding, the default multiply/divide latency and the hardwired zero register.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } mdu_state_t;

    localparam int         MDU_LAT_DEFAULT = 4;
    localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage : pipe_ctrl_pkg

// File: rtl/mdu_stall_timer.sv
// Multi-cycle MDU stall timer. Raises busy for exactly LAT cycles per accepted
// start: the start cycle itself plus LAT-1 wait cycles counted down in cnt.
// The final wait cycle (cnt==0) releases the pipeline and ignores start,
// because the start request still belongs to the op that is being released.
module mdu_stall_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int LAT = MDU_LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic kill,
    output logic busy
);

    localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

    mdu_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    // State and countdown register; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and busy decode; a taken branch (kill) cancels a start in RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            RUN: begin
                if (start && !kill) begin
                    busy      = 1'b1;
                    state_nxt = MDU_WAIT;
                    cnt_nxt   = LAT_M1;
                end
            end
            MDU_WAIT: begin
                if (cnt != 8'd0) begin
                    busy    = 1'b1;
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

endmodule : mdu_stall_timer

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves taken branches, multi-cycle MDU ops,
// load-use dependencies and jumps into stall/flush controls for the F, D and E
// pipeline registers, and keeps a saturating count of front-end stall cycles.
// Priority: taken branch > MDU > load-use > jump, except that an MDU op already
// in its wait phase holds the pipeline regardless of any other input.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rtE,
    input  logic        memtoregE,
    input  logic        jumpD,
    input  logic        pcsrcE,
    input  logic        mdu_startE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushD,
    output logic        flushE,
    output logic [15:0] stall_cycles
);

    logic mdu_busy;
    logic load_use;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF))
            return v + 16'd1;
        return v;
    endfunction

    mdu_stall_timer #(
        .LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk   (clk),
        .reset (reset),
        .start (mdu_startE),
        .kill  (pcsrcE),
        .busy  (mdu_busy)
    );

    // A load writing r0 never creates a dependency since r0 is hardwired zero.
    assign load_use = memtoregE && (rtE != REG_ZERO) && ((rtE == rsD) || (rtE == rtD));

    // Priority resolution; during reset the flushes clear the pipeline registers.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (mdu_busy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
        end else if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (jumpD) begin
            flushD = 1'b1;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= 16'd0;
        else
            stall_cycles <= sat_inc16(stall_cycles, stallF);
    end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a count-based reference model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  rsD, rtD, rtE;
    logic        memtoregE, jumpD, pcsrcE, mdu_startE;
    logic        stallF, stallD, stallE, flushD, flushE;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    // reference model: remaining stalled wait cycles, release-cycle flag, stall count
    int m_wait = 0;
    bit m_rel  = 1'b0;
    int m_sc   = 0;

    pipe_hazard_ctrl #(
        .MDU_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rsD          (rsD),
        .rtD          (rtD),
        .rtE          (rtE),
        .memtoregE    (memtoregE),
        .jumpD        (jumpD),
        .pcsrcE       (pcsrcE),
        .mdu_startE   (mdu_startE),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .flushD       (flushD),
        .flushE       (flushE),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rte, input logic mem, input logic j,
                       input logic pc, input logic ms);
        reset      = r;
        rsD        = rs;
        rtD        = rt;
        rtE        = rte;
        memtoregE  = mem;
        jumpD      = j;
        pcsrcE     = pc;
        mdu_startE = ms;
    endtask

    // One cycle: inputs are already applied at the negedge; compare the
    // outputs against the model, advance the model, move to the next negedge.
    task automatic step(input string tag);
        logic [4:0] exp_v;   // {stallF, stallD, stallE, flushD, flushE}
        logic       lu;
        int         nwait;
        bit         nrel;
        #1;
        lu    = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
        nwait = m_wait;
        nrel  = 1'b0;
        if (reset) begin
            exp_v = 5'b00011;
            nwait = 0;
        end else if (m_wait > 0) begin
            exp_v = 5'b11100;
            nwait = m_wait - 1;
            nrel  = (nwait == 0);
        end else if (pcsrcE) begin
            exp_v = 5'b00011;
        end else if (mdu_startE && !m_rel) begin
            exp_v = 5'b11100;
            nwait = LAT - 1;
        end else if (lu) begin
            exp_v = 5'b11001;
        end else if (jumpD) begin
            exp_v = 5'b00010;
        end else begin
            exp_v = 5'b00000;
        end
        check({tag, " ctl"}, {27'd0, stallF, stallD, stallE, flushD, flushE}, {27'd0, exp_v});
        check({tag, " cnt"}, {16'd0, stall_cycles}, m_sc);
        if (reset)
            m_sc = 0;
        else if (exp_v[4] && m_sc < 65535)
            m_sc = m_sc + 1;
        m_wait = nwait;
        m_rel  = nrel;
        @(negedge clk);
    endtask

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // reset: flushes asserted, stalls low, counter cleared
        step("reset0");
        step("reset1");
        check("reset_sc", {16'd0, stall_cycles}, 32'd0);

        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step("idle");

        // load-use stall for one cycle, then gone once the load advances
        drv(0, 5, 7, 5, 1, 0, 0, 0);
        step("lu_rs");
        drv(0, 3, 5, 5, 1, 0, 0, 0);
        step("lu_rt");
        drv(0, 5, 7, 9, 0, 0, 0, 0);
        step("lu_off");
        // r0 destination never stalls
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        step("lu_r0");

        // taken branch beats load-use; jump alone; load-use beats jump
        drv(0, 5, 5, 5, 1, 0, 1, 0);
        step("br_lu");
        drv(0, 1, 2, 3, 0, 1, 0, 0);
        step("jump");
        drv(0, 6, 1, 6, 1, 1, 0, 0);
        step("jmp_lu");
        drv(0, 6, 1, 9, 0, 1, 0, 0);
        step("jmp_re");
        // taken branch cancels an MDU start
        drv(0, 0, 0, 0, 0, 0, 1, 1);
        step("br_mdu");
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step("br_mdu_after");

        // MDU with start held: exactly LAT stall cycles, low on the next
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        step("mdu_rst");
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < LAT; i++) step("mdu_hold");
        #1;
        check("mdu_release_stallF", {31'd0, stallF}, 32'd0);
        check("mdu_total", {16'd0, stall_cycles}, LAT);
        step("mdu_rel");
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step("mdu_idle");

        // reset during the second wait cycle of an MDU op
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        step("rmdu_start");
        drv(0, 0, 0, 0, 1, 1, 1, 0);
        step("rmdu_w1");
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        step("rmdu_w2_reset");
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rmdu_sc", {16'd0, stall_cycles}, 32'd0);
        check("rmdu_stallF", {31'd0, stallF}, 32'd0);
        step("rmdu_after");

        // saturation: persistent load-use for 65,540 cycles
        drv(0, 8, 0, 8, 1, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step("sat");
        check("sat_value", {16'd0, stall_cycles}, 32'h0000FFFF);
        step("sat_hold");
        check("sat_hold_value", {16'd0, stall_cycles}, 32'h0000FFFF);

        // random traffic with small register numbers to make hazards frequent
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(0, 49) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
